// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Rising-edge detector on the baud divider toggle; one-cycle registered tick per bit period.
module baud_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic baud_toggle,
  output logic tick
);

  logic prev;

  // History loads the live input on reset so a toggle already high is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= baud_toggle;
      tick <= 1'b0;
    end else begin
      prev <= baud_toggle;
      tick <= baud_toggle & ~prev;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional even parity, stop bits.
// Even parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_toggle,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_e state, state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic stop_cnt;
  logic tick;
  logic accept;
  logic last_bit;
  logic last_stop;
`ifdef UART_TX_PARITY_EN
  logic parity;
`endif

  baud_tick_gen u_tick (
    .clk        (clk),
    .rst        (rst),
    .baud_toggle(baud_toggle),
    .tick       (tick)
  );

  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_stop = (stop_cnt == LAST_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        shreg    <= tx_data;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity   <= ^tx_data;
`endif
      end else if (tick && state == DATA) begin
        shreg   <= shreg >> 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end else if (tick && state == STOP) begin
        stop_cnt <= last_stop ? 1'b0 : stop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    tx_serial  = UART_IDLE_LEVEL;
    tx_done    = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = SYNC;
      SYNC:  if (tick) state_next = START;
      START: begin
        tx_serial = UART_START_LEVEL;
        if (tick) state_next = DATA;
      end
      DATA: begin
        tx_serial = shreg[0];
`ifdef UART_TX_PARITY_EN
        if (tick && last_bit) state_next = PARITY;
`else
        if (tick && last_bit) state_next = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_serial = parity;
        if (tick) state_next = STOP;
      end
`endif
      STOP: begin
        // Reset in the same cycle as the final tick abandons the frame, so no done pulse.
        if (tick && last_stop) begin
          tx_done    = !rst;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: one instance with 1 stop bit, one with 2 stop bits.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 10 : 9;

  typedef struct {
    int unsigned dut;
    logic [7:0]  data;
    logic        par;
  } vec_t;

  typedef struct {
    int unsigned dut;
    logic [9:0]  bits;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       baud_toggle;
  logic [7:0] tx_data  [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic       tx_serial[2];
  logic       tx_busy  [2];
  logic       tx_done  [2];

  int total;
  int bad;
  frame_t exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] build_frame(input logic [7:0] d, input logic p);
    build_frame = {(PAR ? p : 1'b0), d, 1'b0};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_toggle = 1'b1;
    forever begin
      repeat (4) @(negedge clk);
      baud_toggle = ~baud_toggle;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NSTOP = (g + 1) * 8;

    uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .baud_toggle(baud_toggle),
      .tx_data    (tx_data[g]),
      .tx_valid   (tx_valid[g]),
      .tx_ready   (tx_ready[g]),
      .tx_serial  (tx_serial[g]),
      .tx_busy    (tx_busy[g]),
      .tx_done    (tx_done[g])
    );

    // Frame monitor: every cycle of every bit is checked against the first sample of that bit.
    initial begin : mon
      logic prev, ok, aborted;
      logic [9:0] cap;
      frame_t e;
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev = 1'b1;
        end else if (prev && !tx_serial[g]) begin
          cap = '0;
          ok = 1'b1;
          aborted = 1'b0;
          for (int b = 0; b < NB && !aborted; b++) begin
            for (int c = 0; c < 8 && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst) aborted = 1'b1;
              else begin
                if (c == 0) cap[b] = tx_serial[g];
                else if (tx_serial[g] !== cap[b]) ok = 1'b0;
                if (tx_done[g] !== 1'b0) ok = 1'b0;
              end
            end
          end
          for (int c = 0; c < NSTOP && !aborted; c++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
            else begin
              if (tx_serial[g] !== 1'b1) ok = 1'b0;
              if (tx_done[g] !== (c == NSTOP - 1)) ok = 1'b0;
            end
          end
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 32'(g), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            if (!aborted) begin
              check("frame_dut", 32'(g), 32'(e.dut));
              check("frame_bits", 32'(cap), 32'(e.bits));
              check("frame_timing", 32'(ok), 32'd1);
              @(negedge clk);
              check("ready_after_done", 32'(tx_ready[g]), 32'd1);
            end
          end
          prev = 1'b1;
        end else begin
          prev = tx_serial[g];
        end
      end
    end
  end

  task automatic send(input int unsigned g, input logic [7:0] d, input logic p);
    int n;
    exp_q.push_back('{g, build_frame(d, p)});
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    n = 0;
    while (!tx_ready[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 300), 32'd1);
    @(negedge clk);
    tx_valid[g] = 1'b0;
    tx_data[g]  = 8'($urandom);
    check("accept_busy", 32'(tx_busy[g]), 32'd1);
    check("accept_ready", 32'(tx_ready[g]), 32'd0);
  endtask

  task automatic wait_idle(input int unsigned g);
    int n;
    n = 0;
    while (tx_busy[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < 400), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    total = 0;
    bad = 0;
    vecs[0] = '{0, 8'hA5, 1'b0};
    vecs[1] = '{0, 8'h07, 1'b1};
    vecs[2] = '{0, 8'h03, 1'b0};
    vecs[3] = '{0, 8'hFF, 1'b0};
    vecs[4] = '{0, 8'h80, 1'b1};
    vecs[5] = '{1, 8'h00, 1'b0};
    vecs[6] = '{1, 8'hC3, 1'b0};
    vecs[7] = '{1, 8'h01, 1'b1};
    for (int i = 0; i < 2; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_serial", 32'(tx_serial[i]), 32'd1);
      check("rst_ready", 32'(tx_ready[i]), 32'd1);
      check("rst_busy", 32'(tx_busy[i]), 32'd0);
      check("rst_done", 32'(tx_done[i]), 32'd0);
    end
    check("rst_no_tick", 32'(g_dut[0].u_dut.tick), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].dut, vecs[i].data, vecs[i].par);
      wait_idle(vecs[i].dut);
    end

    // Back-to-back on the 2-stop instance; data changes while busy must not be latched.
    exp_q.push_back('{1, build_frame(8'h55, 1'b0)});
    tx_data[1]  = 8'h55;
    tx_valid[1] = 1'b1;
    n = 0;
    while (!tx_busy[1] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_accept", 32'(n < 300), 32'd1);
    tx_data[1] = 8'h0F;
    exp_q.push_back('{1, build_frame(8'h0F, 1'b0)});
    n = 0;
    while (!tx_ready[1] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_wait", 32'(n < 300), 32'd1);
    @(negedge clk);
    check("b2b_second_accept", 32'(tx_busy[1]), 32'd1);
    tx_valid[1] = 1'b0;
    wait_idle(1);

    // Reset in the middle of data bit 3.
    send(0, 8'h3C, 1'b0);
    n = 0;
    while (tx_serial[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("start_wait", 32'(n < 300), 32'd1);
    repeat (8 + 3 * 8 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_serial", 32'(tx_serial[0]), 32'd1);
    check("midrst_busy", 32'(tx_busy[0]), 32'd0);
    check("midrst_ready", 32'(tx_ready[0]), 32'd1);
    check("midrst_done", 32'(tx_done[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_done[0]) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    send(0, 8'h81, 1'b0);
    wait_idle(0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer consuming the baud-rate toggle produced by the baud clock divider. Accepts a parallel byte over a valid/ready handshake and shifts it out as an asynchronous serial frame (start, data LSB-first, optional parity, stop) on `tx_serial`. Each serial bit lasts exactly one divider toggle period. It sits between the transmit data source and the board TX pin.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk`  in  1  system clock (50 MHz); all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `baud_toggle`  in  1  divider output; flips every half bit period.
- `tx_data`  in  DATA_WIDTH  payload; sampled on accept.
- `tx_valid`  in  1  source has a payload.
- `tx_ready`  out  1  block accepts a payload this cycle.
- `tx_serial`  out  1  serial line; idle high.
- `tx_busy`  out  1  frame in progress (state != IDLE).
- `tx_done`  out  1  one-cycle pulse at end of last stop bit.

## Operation
- Tick generation: `tick` is a registered one-cycle pulse on each rising edge of `baud_toggle` (`baud_toggle & ~prev`). One bit period runs from one tick to the next.
- Accept: `tx_valid && tx_ready` latches `tx_data` into the shift register. `tx_ready = (state == IDLE)`. `tx_data` is don't-care outside the accept cycle.
- FSM states:
  - IDLE: `tx_serial` = 1. Moves to SYNC on accept.
  - SYNC: line held high. Moves to START on `tick`.
  - START: `tx_serial` = 0. Moves to DATA on `tick`.
  - DATA: `tx_serial` = `shreg[0]`. On each `tick`: shift right and increment `bit_cnt` (width `$clog2(DATA_WIDTH)`). After the tick ending bit DATA_WIDTH-1, moves to PARITY (if compiled in) or STOP.
  - PARITY: `tx_serial` = even parity of the latched payload. Moves to STOP on `tick`.
  - STOP: `tx_serial` = 1 for STOP_BITS tick periods (`stop_cnt`). Final tick: pulse `tx_done`, return to IDLE.
- Ticks seen in IDLE are ignored.
- `tx_valid` asserted while busy has no effect: no accept, no latch.
- Reset values: state IDLE, `tx_serial` 1, `tx_ready` 1 (first cycle after reset), `tx_busy` 0, `tx_done` 0, shift register and counters 0.
- The edge-detect history register loads the current `baud_toggle` on reset, so no false tick is produced.
- Reset mid-frame: at the next clock edge the frame is abandoned and the line returns high immediately. No `tx_done` is produced.

## Timing
- Tick latency: `baud_toggle` rising at cycle N gives `tick` high in cycle N+1 (registered). The state and `tx_serial` update at the end of that cycle, i.e. visible in N+2.
- Accept at cycle A: state SYNC and `tx_ready` = 0 from A+1.
- Start bit begins at the first tick after A. Latency to start bit is 1 to P+2 cycles, where P = clocks per bit.
- Frame length, in tick periods, from start-bit edge to `tx_done`: 1 + DATA_WIDTH + parity + STOP_BITS.
- `tx_done` is high in the cycle the FSM leaves STOP. `tx_ready` rises the following cycle.
- Back-to-back frames: with `tx_valid` held high, the next accept happens in the first cycle `tx_ready` is 1. The line stays high through SYNC, which is at least part of an extra bit period.
- A tick and `rst` in the same cycle: reset wins.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is included; frame has 1 + DATA_WIDTH + 1 + STOP_BITS bits; parity is even (XOR of the payload).
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are absent; DATA goes straight to STOP.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_e` enum (IDLE, SYNC, START, DATA, PARITY, STOP).
  - `UART_IDLE_LEVEL` = 1'b1.
  - `UART_START_LEVEL` = 1'b0.
- Sub-module `baud_tick_gen`: rising-edge detector on `baud_toggle` with a registered pulse output and synchronous reset to the current input value.
- Top module: FSM, shift register, bit/stop counters, handshake.

## Test plan
- Bench `baud_toggle` half-period of 4 clocks (8 clocks/bit).
- Reset: hold `rst` 3 cycles → `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 on first post-reset cycle; no tick while `baud_toggle` is already high.
- Single frame 0xA5, no parity, STOP_BITS=1 → line sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks; one `tx_done` pulse; `tx_ready` high next cycle.
- `UART_TX_PARITY_EN`, payload 0x07 → parity bit 1; payload 0x03 → parity bit 0; 11-bit frame.
- STOP_BITS=2, `tx_valid` held high with 0x55 then 0x0F → two complete frames, stop level held 16 clocks each; `tx_valid` ignored while busy.
- Reset asserted during DATA bit 3 → next cycle `tx_serial`=1, state IDLE, no `tx_done`; a following frame 0x81 transmits correctly.
